adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Emulates the MCP3002-style 2-channel 10-bit SPI ADC from the device side. It is the responder to the spi2adc initiator.
- It decodes the serial command on SDI, selects a channel or differential pair, and shifts the 10-bit result out on SDO.
- Used in simulation and on-FPGA loopback, so ex16-style audio paths can be exercised without the physical ADC. Sample values come from ch0_data/ch1_data.
- All SPI pins are oversampled in the sysclk domain.

Parameters:
- SYNC_STAGES, 2, number of flops in each synchroniser on adc_sck, adc_cs and sdata_to_adc (minimum 2).
- DATA_W, 10, conversion result width.

Ports:
- sysclk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- adc_cs  input  1  chip select from initiator, low active.
- adc_sck  input  1  SPI clock from initiator; idles high or low.
- sdata_to_adc  input  1  command bits from initiator (device DIN).
- sdata_from_adc  output  1  result bits to initiator (device DOUT).
- sdo_oe  output  1  high while DOUT is actively driven; the pad is high-Z otherwise.
- ch0_data  input  DATA_W  analogue value presented on CH0.
- ch1_data  input  DATA_W  analogue value presented on CH1.
- cfg  output  3  last decoded {SGL/DIFF, ODD/SIGN, MSBF}.
- frame_done  output  1  one-sysclk pulse when all MSB-first data bits have been shifted.
- frame_abort  output  1  one-sysclk pulse when adc_cs rises before frame_done.

Behaviour:
- Reset values: sdata_from_adc=0, sdo_oe=0, cfg=3'b000, frame_done=0, frame_abort=0, state=IDLE, all synchronisers cleared (adc_cs sync cleared to 1).
- Synchronisers: adc_sck, adc_cs and sdata_to_adc each pass through SYNC_STAGES flops.
  - A rise or fall is detected by comparing the last stage with one extra registered copy.
  - Edge-to-action latency is SYNC_STAGES+1 sysclk.
  - The initiator's SCK half-period must be at least SYNC_STAGES+2 sysclk.
- Rising SCK edge: sample synchronised SDI. Falling SCK edge: update sdata_from_adc.
- States:
  - IDLE: sync cs high; sdo_oe=0. Falling cs -> WAIT_START.
  - WAIT_START: on each rising SCK, SDI=0 is ignored (leading zeros allowed, unbounded). SDI=1 -> CFG with bit counter=0.
  - CFG: shift 3 bits (SGL/DIFF, ODD/SIGN, MSBF) on rising edges.
    - On the 3rd bit, latch cfg and snapshot the conversion result into a DATA_W shift register, then go to NULL.
    - Result: SGL=1 gives ch0_data if ODD=0, ch1_data if ODD=1.
    - SGL=0 gives ch0−ch1 (ODD=0) or ch1−ch0 (ODD=1), computed DATA_W+1 wide and saturated to 0 when negative.
    - ch0_data/ch1_data changes after the snapshot do not affect the frame.
  - NULL: next falling SCK sets sdo_oe=1, sdata_from_adc=0 -> DATA_MSB.
  - DATA_MSB: each falling SCK drives the next bit D9..D0 (10 falling edges).
    - frame_done pulses on the sysclk after D0 is driven.
    - Then MSBF=1 -> TAIL; MSBF=0 -> DATA_LSB.
  - DATA_LSB: falling edges drive D1..D9 (9 bits; D0 is not repeated), then -> TAIL.
  - TAIL: sdata_from_adc=0, sdo_oe stays 1 until cs rises.
- Rising cs in any non-IDLE state:
  - Forces IDLE with sdo_oe=0 and sdata_from_adc=0 within SYNC_STAGES+1 sysclk.
  - frame_abort pulses if frame_done has not yet pulsed in this frame.
  - cfg retains its last value.
- Simultaneous events: a cs rise detected in the same sysclk as an SCK edge wins; the SCK edge is discarded.
- SCK edges while cs is high are ignored.
- rst_n low at any time (including mid-frame) takes effect immediately and asynchronously, returning all outputs to their reset values.
- frame_done and frame_abort are never both asserted in one frame.

Test Plan:
- ch1_data=10'h2A5; cs low, SDI 1,1,1,1 (start, SGL, ODD, MSBF=1) -> cfg=3'b111. Null 0, then SDO 1,0,1,0,1,0,0,1,0,1. frame_done pulses once, sdo_oe falls after cs rises, no frame_abort.
- ch0_data=10'h301; command start,1,0,0 (MSBF=0) -> SDO null, 1100000001, then LSB-first D1..D9 = 0,0,0,0,0,0,0,1,1. Zeros after that until cs rises.
- Five leading zero SDI bits before the start bit, ch0_data=10'h155, command 1,1,0,1 -> identical response to the same frame without the leading zeros.
- Differential: ch0=10'd100, ch1=10'd40, SGL=0 ODD=0 -> 10'd60. ODD=1 -> 10'd0 (saturated). ch0=10'h3FF, ch1=0, ODD=0 -> 10'h3FF.
- cs raised after D5 is shifted -> frame_abort pulses once, no frame_done. Next full frame returns correct data.
- rst_n pulsed low mid-DATA_MSB -> sdata_from_adc=0 and sdo_oe=0 immediately. A new frame after reset is decoded correctly.

Source files
------------

// File: rtl/adc_spi_responder.sv
// Device-side model of an MCP3002-style 2-channel 10-bit SPI ADC.
// All SPI pins are oversampled in the sysclk domain; result bits come from ch0_data/ch1_data.
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 10
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              adc_cs,
   input  logic              adc_sck,
   input  logic              sdata_to_adc,
   output logic              sdata_from_adc,
   output logic              sdo_oe,
   input  logic [DATA_W-1:0] ch0_data,
   input  logic [DATA_W-1:0] ch1_data,
   output logic [2:0]        cfg,
   output logic              frame_done,
   output logic              frame_abort
);

   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      IDLE, WAIT_START, CFG, NULL_BIT, DATA_MSB, DATA_LSB, TAIL
   } state_t;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
   logic                   sck_d, cs_d;
   logic                   sck_s, cs_s, sdi_s;
   logic                   sck_rise, sck_fall, cs_rise, cs_fall;

   state_t            state, state_nx;
   logic [1:0]        cmd_q, cmd_nx;
   logic [1:0]        cmd_cnt, cmd_cnt_nx;
   logic [IDX_W-1:0]  idx, idx_nx;
   logic [DATA_W-1:0] res, res_nx;
   logic [2:0]        cfg_nx;
   logic              sdo_nx, oe_nx, done_nx, abort_nx;
   logic              done_seen, seen_nx;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] conv;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync <= '0;
         sdi_sync <= '0;
         cs_sync  <= '1;
         sck_d    <= 1'b0;
         cs_d     <= 1'b1;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdata_to_adc};
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
         sck_d    <= sck_sync[SYNC_STAGES-1];
         cs_d     <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign cs_rise  = cs_s & ~cs_d;
   assign cs_fall  = ~cs_s & cs_d;

   // Conversion result from the SGL/ODD bits already shifted in; differential clamps at zero.
   always_comb begin
      diff = '0;
      if (cmd_q[1]) begin
         conv = cmd_q[0] ? ch1_data : ch0_data;
      end else begin
         diff = cmd_q[0] ? ({1'b0, ch1_data} - {1'b0, ch0_data})
                         : ({1'b0, ch0_data} - {1'b0, ch1_data});
         conv = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
      end
   end

   // NOTE: every signal gets a default before the case so no latches are inferred.
   always_comb begin
      state_nx   = state;
      cmd_nx     = cmd_q;
      cmd_cnt_nx = cmd_cnt;
      idx_nx     = idx;
      res_nx     = res;
      cfg_nx     = cfg;
      sdo_nx     = sdata_from_adc;
      oe_nx      = sdo_oe;
      seen_nx    = done_seen;
      done_nx    = 1'b0;
      abort_nx   = 1'b0;

      if (state != IDLE && cs_rise) begin
         state_nx = IDLE;
         oe_nx    = 1'b0;
         sdo_nx   = 1'b0;
         abort_nx = ~done_seen;
      end else begin
         unique case (state)
            IDLE: if (cs_fall) begin
               state_nx = WAIT_START;
               seen_nx  = 1'b0;
            end
            WAIT_START: if (sck_rise && sdi_s) begin
               state_nx   = CFG;
               cmd_cnt_nx = '0;
            end
            CFG: if (sck_rise) begin
               cmd_nx     = {cmd_q[0], sdi_s};
               cmd_cnt_nx = cmd_cnt + 2'd1;
               if (cmd_cnt == 2'd2) begin
                  cfg_nx   = {cmd_q, sdi_s};
                  res_nx   = conv;
                  state_nx = NULL_BIT;
               end
            end
            NULL_BIT: if (sck_fall) begin
               oe_nx    = 1'b1;
               sdo_nx   = 1'b0;
               idx_nx   = IDX_W'(DATA_W-1);
               state_nx = DATA_MSB;
            end
            DATA_MSB: if (sck_fall) begin
               sdo_nx = res[idx];
               if (idx == '0) begin
                  done_nx  = 1'b1;
                  seen_nx  = 1'b1;
                  idx_nx   = IDX_W'(1);
                  state_nx = cfg[0] ? TAIL : DATA_LSB;
               end else begin
                  idx_nx = idx - IDX_W'(1);
               end
            end
            DATA_LSB: if (sck_fall) begin
               sdo_nx = res[idx];
               if (idx == IDX_W'(DATA_W-1)) state_nx = TAIL;
               else                         idx_nx   = idx + IDX_W'(1);
            end
            TAIL: if (sck_fall) sdo_nx = 1'b0;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cmd_q          <= '0;
         cmd_cnt        <= '0;
         idx            <= '0;
         res            <= '0;
         cfg            <= 3'b000;
         sdata_from_adc <= 1'b0;
         sdo_oe         <= 1'b0;
         done_seen      <= 1'b0;
         frame_done     <= 1'b0;
         frame_abort    <= 1'b0;
      end else begin
         state          <= state_nx;
         cmd_q          <= cmd_nx;
         cmd_cnt        <= cmd_cnt_nx;
         idx            <= idx_nx;
         res            <= res_nx;
         cfg            <= cfg_nx;
         sdata_from_adc <= sdo_nx;
         sdo_oe         <= oe_nx;
         done_seen      <= seen_nx;
         frame_done     <= done_nx;
         frame_abort    <= abort_nx;
      end
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: an SPI initiator drives frames, a queue holds expected pin values.
module tb_adc_spi_responder;

   localparam int DATA_W = 10;
   localparam int SYNC   = 2;
   localparam int HALF   = 8;

   logic              sysclk = 1'b0;
   logic              rst_n = 1'b0;
   logic              adc_cs = 1'b1;
   logic              adc_sck = 1'b0;
   logic              sdata_to_adc = 1'b0;
   logic              sdata_from_adc, sdo_oe, frame_done, frame_abort;
   logic [DATA_W-1:0] ch0_data = '0;
   logic [DATA_W-1:0] ch1_data = '0;
   logic [2:0]        cfg;

   int n_checks = 0;
   int n_fails  = 0;
   int done_cnt = 0;
   int abort_cnt = 0;
   logic [1:0] exp_q[$];

   adc_spi_responder #(.SYNC_STAGES(SYNC), .DATA_W(DATA_W)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .adc_cs(adc_cs), .adc_sck(adc_sck),
      .sdata_to_adc(sdata_to_adc), .sdata_from_adc(sdata_from_adc), .sdo_oe(sdo_oe),
      .ch0_data(ch0_data), .ch1_data(ch1_data), .cfg(cfg),
      .frame_done(frame_done), .frame_abort(frame_abort)
   );

   always #10 sysclk = ~sysclk;

   always @(negedge sysclk) begin
      if (frame_done)  done_cnt++;
      if (frame_abort) abort_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   function automatic logic [DATA_W-1:0] model(input logic [2:0] c, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      int d;
      if (c[2]) return c[1] ? b : a;
      d = c[1] ? (int'(b) - int'(a)) : (int'(a) - int'(b));
      return (d < 0) ? '0 : DATA_W'(d);
   endfunction

   // Expected {sdo_oe, sdata_from_adc} just before rising SCK number k (k=1 carries the start bit).
   function automatic logic [1:0] exp_pins(input int k, input logic [2:0] c, input logic [DATA_W-1:0] v);
      if (k <= 4)  return 2'b00;
      if (k == 5)  return 2'b10;
      if (k <= 15) return {1'b1, v[15-k]};
      if (!c[0] && k <= 24) return {1'b1, v[k-15]};
      return 2'b10;
   endfunction

   task automatic run_frame(input string tag, input int n_lead, input logic [2:0] c,
                            input int n_clk, input int rst_at);
      logic [DATA_W-1:0] v;
      logic [3:0]        cmd;
      logic [1:0]        e;
      int                d0, a0;
      v   = model(c, ch0_data, ch1_data);
      cmd = {1'b1, c};
      d0  = done_cnt;
      a0  = abort_cnt;
      for (int k = 1; k <= n_clk; k++) exp_q.push_back(exp_pins(k, c, v));

      adc_cs = 1'b0;
      cyc(HALF);
      for (int i = 0; i < n_lead; i++) begin
         sdata_to_adc = 1'b0;
         cyc(HALF);
         adc_sck = 1'b1;
         cyc(HALF);
         adc_sck = 1'b0;
      end
      for (int k = 1; k <= n_clk; k++) begin
         sdata_to_adc = (k <= 4) ? cmd[4-k] : 1'b0;
         cyc(HALF);
         e = exp_q.pop_front();
         check($sformatf("%s pins@%0d", tag, k), {30'd0, sdo_oe, sdata_from_adc}, {30'd0, e});
         adc_sck = 1'b1;
         if (k == 6) begin
            ch0_data = DATA_W'($urandom);
            ch1_data = DATA_W'($urandom);
         end
         cyc(HALF);
         adc_sck = 1'b0;
         if (k == rst_at) begin
            cyc(4);
            check({tag, " oe_before_rst"}, 32'(sdo_oe), 32'd1);
            rst_n = 1'b0;
            #1;
            check({tag, " oe_in_rst"}, 32'(sdo_oe), 32'd0);
            check({tag, " sdo_in_rst"}, 32'(sdata_from_adc), 32'd0);
            check({tag, " cfg_in_rst"}, 32'(cfg), 32'd0);
            adc_cs = 1'b1;
            cyc(3);
            rst_n = 1'b1;
            cyc(HALF);
            check({tag, " no_abort_on_rst"}, 32'(abort_cnt - a0), 32'd0);
            check({tag, " no_done_on_rst"}, 32'(done_cnt - d0), 32'd0);
            exp_q.delete();
            return;
         end
      end
      cyc(HALF);
      adc_cs = 1'b1;
      cyc(SYNC + 6);
      check({tag, " oe_after_cs"}, 32'(sdo_oe), 32'd0);
      check({tag, " sdo_after_cs"}, 32'(sdata_from_adc), 32'd0);
      check({tag, " cfg"}, 32'(cfg), 32'(c));
      check({tag, " done_pulses"}, 32'(done_cnt - d0), (n_clk >= 14) ? 32'd1 : 32'd0);
      check({tag, " abort_pulses"}, 32'(abort_cnt - a0), (n_clk >= 14) ? 32'd0 : 32'd1);
      cyc(HALF);
   endtask

   initial begin
      cyc(3);
      check("rst sdo", 32'(sdata_from_adc), 32'd0);
      check("rst oe", 32'(sdo_oe), 32'd0);
      check("rst cfg", 32'(cfg), 32'd0);
      check("rst done", 32'(frame_done), 32'd0);
      check("rst abort", 32'(frame_abort), 32'd0);
      rst_n = 1'b1;
      cyc(4);

      ch0_data = 10'h000; ch1_data = 10'h2A5;
      run_frame("msb_ch1", 0, 3'b111, 16, 0);
      ch0_data = 10'h301;
      run_frame("lsb_ch0", 0, 3'b100, 26, 0);
      ch0_data = 10'h155;
      run_frame("lead_zeros", 5, 3'b101, 18, 0);
      ch0_data = 10'h155;
      run_frame("no_lead", 0, 3'b101, 18, 0);

      ch0_data = 10'd100; ch1_data = 10'd40;
      run_frame("diff_0m1", 0, 3'b001, 16, 0);
      ch0_data = 10'd100; ch1_data = 10'd40;
      run_frame("diff_sat", 0, 3'b011, 16, 0);
      ch0_data = 10'h3FF; ch1_data = 10'h000;
      run_frame("diff_max", 0, 3'b001, 16, 0);

      ch1_data = 10'h1C3;
      run_frame("abort", 0, 3'b111, 9, 0);
      ch1_data = 10'h1C3;
      run_frame("after_abort", 0, 3'b111, 16, 0);

      ch0_data = 10'h0F0; ch1_data = 10'h2A5;
      run_frame("reset_mid", 0, 3'b110, 16, 10);
      ch0_data = 10'h0F0; ch1_data = 10'h2A5;
      run_frame("after_reset", 0, 3'b110, 20, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
